// File: rtl/gsim_pkg.sv
// Shared types and constants for the Gauss-Seidel sequencer and the computation-unit wrapper.
package gsim_pkg;

  localparam int N_ROW  = 16;
  localparam int ROW_W  = 4;
  localparam int ITER_W = 8;
  localparam int NBR_W  = 6;

  // Bit positions inside nbr_mask: P = x[r+k], M = x[r-k].
  localparam int NBR_P1 = 0;
  localparam int NBR_M1 = 1;
  localparam int NBR_P2 = 2;
  localparam int NBR_M2 = 3;
  localparam int NBR_P3 = 4;
  localparam int NBR_M3 = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ITER,
    ST_DRAIN,
    ST_OUT
  } gsim_state_e;

endpackage

// File: rtl/gsim_nbr_mask.sv
// Neighbour-valid mask for a row: clears operands that fall outside the 0..N_ROW-1 band.
module gsim_nbr_mask
  import gsim_pkg::*;
#(
  parameter int N_ROW = gsim_pkg::N_ROW
) (
  input  logic [ROW_W-1:0] row_idx,
  output logic [NBR_W-1:0] nbr_mask
);

  always_comb begin
    nbr_mask         = '0;
    nbr_mask[NBR_P1] = int'(row_idx) < N_ROW - 1;
    nbr_mask[NBR_M1] = int'(row_idx) > 0;
    nbr_mask[NBR_P2] = int'(row_idx) < N_ROW - 2;
    nbr_mask[NBR_M2] = int'(row_idx) > 1;
    nbr_mask[NBR_P3] = int'(row_idx) < N_ROW - 3;
    nbr_mask[NBR_M3] = int'(row_idx) > 2;
  end

endmodule

// File: rtl/gsim_sequencer.sv
// Gauss-Seidel solve sequencer: loads the b vector, issues row computations for ITER sweeps,
// tracks the one-cycle computation-unit writeback and streams the result vector out.
module gsim_sequencer
  import gsim_pkg::*;
#(
  parameter int N_ROW = gsim_pkg::N_ROW,
  parameter int ITER  = 100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_en,
  input  logic              hold,
  output logic              b_wr_en,
  output logic [ROW_W-1:0]  b_wr_addr,
  output logic              cu_valid,
  output logic [ROW_W-1:0]  row_idx,
  output logic [NBR_W-1:0]  nbr_mask,
  output logic              fwd_sel,
  output logic              wb_en,
  output logic [ROW_W-1:0]  wb_addr,
  output logic              out_valid,
  output logic [ROW_W-1:0]  out_addr,
  output logic [ITER_W-1:0] iter_cnt,
  output logic              busy,
  output logic              done
);

  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(N_ROW - 1);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(ITER - 1);

  gsim_state_e       state;
  logic [ROW_W-1:0]  load_cnt;
  logic [ROW_W-1:0]  row_cnt;
  logic [ROW_W-1:0]  out_cnt;
  logic [NBR_W-1:0]  mask_raw;
  logic              issue;
  logic              in_load;

  gsim_nbr_mask #(
    .N_ROW(N_ROW)
  ) u_nbr_mask (
    .row_idx (row_cnt),
    .nbr_mask(mask_raw)
  );

  // b writes are gated by reset so an asserted reset silences the port even in IDLE.
  always_comb begin
    in_load   = (state == ST_IDLE) || (state == ST_LOAD);
    issue     = (state == ST_ITER) && !hold;
    b_wr_en   = reset && in_en && in_load;
    b_wr_addr = b_wr_en ? load_cnt : '0;
    cu_valid  = issue;
    row_idx   = issue ? row_cnt : '0;
    nbr_mask  = issue ? mask_raw : '0;
    fwd_sel   = issue && (row_cnt != '0) && wb_en && (wb_addr == row_cnt - 1'b1);
    out_valid = (state == ST_OUT);
    out_addr  = out_valid ? out_cnt : '0;
    done      = out_valid && (out_cnt == LAST_ROW);
    busy      = (state != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      load_cnt <= '0;
      row_cnt  <= '0;
      out_cnt  <= '0;
      iter_cnt <= '0;
      wb_en    <= 1'b0;
      wb_addr  <= '0;
    end else begin
      // Computation unit has a fixed one-cycle latency, regardless of state or hold.
      wb_en   <= issue;
      wb_addr <= issue ? row_cnt : '0;
      case (state)
        ST_IDLE: begin
          if (in_en) begin
            state    <= ST_LOAD;
            load_cnt <= ROW_W'(1);
            iter_cnt <= '0;
          end
        end
        ST_LOAD: begin
          if (in_en) begin
            if (load_cnt == LAST_ROW) begin
              state    <= ST_ITER;
              load_cnt <= '0;
              row_cnt  <= '0;
              iter_cnt <= '0;
            end else begin
              load_cnt <= load_cnt + 1'b1;
            end
          end
        end
        ST_ITER: begin
          if (!hold) begin
            if (row_cnt == LAST_ROW) begin
              row_cnt  <= '0;
              iter_cnt <= iter_cnt + 1'b1;
              if (iter_cnt == LAST_ITER) begin
                state <= ST_DRAIN;
              end
            end else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          state   <= ST_OUT;
          out_cnt <= '0;
        end
        ST_OUT: begin
          if (out_cnt == LAST_ROW) begin
            state   <= ST_IDLE;
            out_cnt <= '0;
          end else begin
            out_cnt <= out_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
